vga_fetch_arbiter: RTL
======================

// Module: vga_fetch_arbiter
// PURPOSE
//  Schedules one shared single-port frame-memory port between two requesters:
//   - video line prefetch, which has priority and is driven by hpos/vpos from the 640x480 timing generator
//   - a host pixel-write port
//  Fetches line n+1 into one bank of a ping-pong line buffer while line n is displayed from the other bank.
//  Sits between the timing generator, the frame memory and the line buffer.
// PARAMETERS
//  DATA_W          32    memory word width; 4 pixels of 8 bits per word
//  ADDR_W          17    memory word-address width
//  WORDS_PER_LINE  160   words per displayed line (640/4)
//  V_DISPLAY       480   displayed lines
//  V_MAX           501   last vpos of a frame (total 502 lines)
//  H_MAX           783   last hpos of a line (total 784 clocks)
//  BASE_ADDR       0     word address of frame line 0
// PORTS
//  clk_i           in   1       pixel clock
//  rst_i           in   1       asynchronous reset, active-high
//  hpos_i          in   10      horizontal position from timing generator
//  vpos_i          in   9       vertical position from timing generator
//  host_req_i      in   1       host write request; addr/data held stable until grant
//  host_addr_i     in   ADDR_W  host write word address
//  host_data_i     in   DATA_W  host write data
//  host_gnt_o      out  1       1-cycle pulse: host write accepted by memory
//  mem_req_o       out  1       memory request; held with addr/we/wdata until mem_ack_i
//  mem_we_o        out  1       1=write (host), 0=read (fetch)
//  mem_addr_o      out  ADDR_W  memory word address
//  mem_wdata_o     out  DATA_W  memory write data
//  mem_ack_i       in   1       1-cycle ack; mem_rdata_i valid in the same cycle for reads
//  mem_rdata_i     in   DATA_W  memory read data
//  lb_we_o         out  1       line-buffer write strobe
//  lb_addr_o       out  9       {bank, word[7:0]}
//  lb_data_o       out  DATA_W  line-buffer write data
//  underrun_o      out  1       sticky: a line fetch did not complete in time
//  underrun_clr_i  in   1       clears underrun_o
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; no fetch pending. Async assert clears all registers at once.
//   - mem_req_o drops immediately, even mid-transaction; the memory must tolerate an abandoned request.
//  Fetch trigger: at hpos_i==0.
//   - vpos_i==V_MAX: target line 0.
//   - vpos_i+1 < V_DISPLAY: target line vpos_i+1.
//   - Otherwise no fetch.
//   - On trigger: latch target line, bank=line[0], word=0, fetch_pending=1.
//  Address: mem_addr_o = BASE_ADDR + line*WORDS_PER_LINE + word, modulo 2^ADDR_W.
//   - line*160 is computed by shift-add (line<<7 + line<<5); no multiplier.
//  FSM, all outputs registered:
//   - IDLE: if fetch_pending go to FETCH, else if host_req_i go to HOST. Fetch wins a simultaneous request.
//   - FETCH: mem_req_o=1, mem_we_o=0.
//     - On mem_ack_i: lb_we_o=1 in the next cycle with lb_data_o=rdata and lb_addr_o={bank,word}; word++.
//     - When word reaches WORDS_PER_LINE-1 and is acked: fetch_pending=0, go to IDLE.
//     - Otherwise stay in FETCH; the next address is presented the cycle after the ack, so back-to-back words issue without returning to IDLE.
//   - HOST: mem_req_o=1, mem_we_o=1, addr/data from host_* (registered on entry).
//     - On mem_ack_i: host_gnt_o=1 for 1 cycle, then go to IDLE.
//  Host requests are not preempted mid-transaction. Host worst-case wait is one fetch burst plus one transaction.
//  Underrun: a trigger while fetch_pending is still 1 sets underrun_o.
//   - Remaining words of the old line are dropped.
//   - An outstanding request is still completed; its data is written to the old bank.
//   - The new line starts at the next word boundary.
//  underrun_clr_i together with a new underrun event in the same cycle: set wins.
//  Triggers in vertical blanking (target >= V_DISPLAY, not line 0) are ignored; the host gets the full port.
// STRUCTURE
//  Shared package vga_timing_pkg:
//   - H_DISPLAY=640, H_MAX=783, V_DISPLAY=480, V_MAX=501, WORDS_PER_LINE=160
//   - FSM state typedef {IDLE,FETCH,HOST}
//  One sub-module: vga_line_addr, combinational line index -> line base word address (shift-add + BASE_ADDR).
//  Top: trigger decode, FSM, word counter, line-buffer write register, underrun flag.
// TESTING
//  1. Reset mid-FETCH with mem_req_o=1 -> mem_req_o=0 same cycle; all outputs 0; no lb_we_o after release.
//  2. vpos=9, hpos=0, ack every cycle -> 160 lb writes, lb_addr 0x000..0x09F (bank 0, line 10); mem_addr 1600..1759; underrun_o=0.
//  3. vpos=501, hpos=0 -> fetch line 0 into bank 0 at addr 0..159. vpos=479 or 490 -> no mem_req_o.
//  4. host_req_i asserted in the same cycle as the fetch trigger -> fetch burst first; then exactly one host write, host_gnt_o 1 pulse, mem_we_o=1.
//  5. ack only every 8th cycle (160*8 > 784) -> underrun_o=1 at next hpos=0; the new line restarts at word 0; underrun_clr_i clears it.
//  6. Host write with idle fetch, ack delayed 5 cycles -> mem_addr/mem_wdata stable throughout; host_gnt_o on the ack cycle +1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants and fetch-arbiter FSM state type.
package vga_timing_pkg;

  localparam int unsigned H_DISPLAY      = 640;
  localparam int unsigned H_MAX          = 783;
  localparam int unsigned V_DISPLAY      = 480;
  localparam int unsigned V_MAX          = 501;
  localparam int unsigned WORDS_PER_LINE = 160;
  localparam int unsigned LINE_W         = 9;
  localparam int unsigned WORD_W         = 8;
  localparam int unsigned LB_ADDR_W      = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOST  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/vga_line_addr.sv
// Line index to line base word address: BASE_ADDR + line*160 via shift-add.
module vga_line_addr
  import vga_timing_pkg::*;
#(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic [LINE_W-1:0] line_i,
  output logic [ADDR_W-1:0] base_c
);

  // line*160 = (line<<7) + (line<<5); result wraps modulo 2^ADDR_W
  always_comb begin
    base_c = ADDR_W'(BASE_ADDR) + (ADDR_W'(line_i) << 7) + (ADDR_W'(line_i) << 5);
  end

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Shares one frame-memory port between video line prefetch (priority) and host writes.
module vga_fetch_arbiter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [9:0]           hpos_i,
  input  logic [8:0]           vpos_i,
  input  logic                 host_req_i,
  input  logic [ADDR_W-1:0]    host_addr_i,
  input  logic [DATA_W-1:0]    host_data_i,
  output logic                 host_gnt_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 lb_we_o,
  output logic [LB_ADDR_W-1:0] lb_addr_o,
  output logic [DATA_W-1:0]    lb_data_o,
  output logic                 underrun_o,
  input  logic                 underrun_clr_i
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  fsm_state_t               state_q, state_d;
  logic                     pending_q, pending_d;
  logic                     stale_q, stale_d;
  logic [LINE_W-1:0]        line_q, line_d;
  logic [WORD_W-1:0]        word_q, word_d;
  logic [LB_ADDR_W-1:0]     req_lb_q, req_lb_d;
  logic                     mem_req_d, mem_we_d, host_gnt_d;
  logic [ADDR_W-1:0]        mem_addr_d;
  logic [DATA_W-1:0]        mem_wdata_d;
  logic                     lb_we_d, underrun_d;
  logic [LB_ADDR_W-1:0]     lb_addr_d;
  logic [DATA_W-1:0]        lb_data_d;
  logic                     trig_c;
  logic [LINE_W-1:0]        tgt_line_c;
  logic [ADDR_W-1:0]        line_base_c;
  logic [ADDR_W-1:0]        issue_addr_c;

  // Fetch trigger at start of each line: next displayed line, or line 0 at frame end
  always_comb begin
    trig_c     = 1'b0;
    tgt_line_c = '0;
    if (hpos_i == '0) begin
      if (vpos_i == LINE_W'(V_MAX)) begin
        trig_c = 1'b1;
      end else if ((10'(vpos_i) + 10'd1) < 10'(V_DISPLAY)) begin
        trig_c     = 1'b1;
        tgt_line_c = vpos_i + 9'd1;
      end
    end
  end

  vga_line_addr #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_line_addr (
    .line_i (line_d),
    .base_c (line_base_c)
  );

  assign issue_addr_c = line_base_c + ADDR_W'(word_d);

  // Line/word progress, line-buffer write and sticky underrun flag
  always_comb begin
    pending_d  = pending_q;
    stale_d    = stale_q;
    line_d     = line_q;
    word_d     = word_q;
    lb_we_d    = 1'b0;
    lb_addr_d  = lb_addr_o;
    lb_data_d  = lb_data_o;
    underrun_d = underrun_o;
    if (state_q == FETCH && mem_ack_i) begin
      lb_we_d   = 1'b1;
      lb_addr_d = req_lb_q;
      lb_data_d = mem_rdata_i;
      // an ack for a request of an abandoned line does not advance the new line
      if (stale_q) begin
        stale_d = 1'b0;
      end else if (word_q == LAST_WORD) begin
        pending_d = 1'b0;
      end else begin
        word_d = word_q + 8'd1;
      end
    end
    if (trig_c) begin
      line_d    = tgt_line_c;
      word_d    = '0;
      pending_d = 1'b1;
      stale_d   = (state_q == FETCH) && !mem_ack_i;
    end
    if (trig_c && pending_q) begin
      underrun_d = 1'b1;
    end else if (underrun_clr_i) begin
      underrun_d = 1'b0;
    end
  end

  // Port scheduling FSM: fetch has priority, host writes are never preempted
  always_comb begin
    state_d     = state_q;
    req_lb_d    = req_lb_q;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    host_gnt_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_d) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = issue_addr_c;
          req_lb_d   = {line_d[0], word_d};
        end else if (host_req_i && !host_gnt_o) begin
          // the host still shows its request in the grant cycle; do not reissue it
          state_d     = HOST;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = host_addr_i;
          mem_wdata_d = host_data_i;
        end
      end
      FETCH: begin
        if (mem_ack_i) begin
          if (pending_d) begin
            mem_addr_d = issue_addr_c;
            req_lb_d   = {line_d[0], word_d};
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      HOST: begin
        if (mem_ack_i) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          host_gnt_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      stale_q     <= 1'b0;
      line_q      <= '0;
      word_q      <= '0;
      req_lb_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      host_gnt_o  <= 1'b0;
      lb_we_o     <= 1'b0;
      lb_addr_o   <= '0;
      lb_data_o   <= '0;
      underrun_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      stale_q     <= stale_d;
      line_q      <= line_d;
      word_q      <= word_d;
      req_lb_q    <= req_lb_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      host_gnt_o  <= host_gnt_d;
      lb_we_o     <= lb_we_d;
      lb_addr_o   <= lb_addr_d;
      lb_data_o   <= lb_data_d;
      underrun_o  <= underrun_d;
    end
  end

endmodule
